ofs_plat_avalon_mem_rr_arb: RTL

OFS_PLAT_AVALON_MEM_RR_ARB -- requirements
Module: ofs_plat_avalon_mem_rr_arb

---
 rtl/ofs_plat_avalon_mem_rr_arb_pkg.sv | 34 +++
 rtl/ofs_plat_avalon_mem_rr_arb_rd_fifo.sv | 69 ++++++
 rtl/ofs_plat_avalon_mem_rr_arb.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ofs_plat_avalon_mem_rr_arb_pkg.sv
// ============================================================================
// ofs_plat_avalon_mem_rr_arb_pkg
//
// Shared types for the round-robin Avalon-MM bank arbiter:
//   arb_state_t - arbiter command state (free arbitration / locked write burst)
//   rd_tag_t    - read-tracking entry, records which source issued an
//                 outstanding read and how many response beats it expects
//   eff_burst() - maps the Avalon "burstcount 0" encoding to a single beat
//
// The tag fields are fixed-width so the package stays parameter-free; the
// arbiter requires NUM_PORTS <= 2**TAG_PORT_W and
// BURST_CNT_WIDTH <= TAG_BURST_W.
// ============================================================================
package ofs_plat_avalon_mem_rr_arb_pkg;

    localparam int TAG_PORT_W  = 8;
    localparam int TAG_BURST_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WR_BURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [TAG_PORT_W-1:0]  port;
        logic [TAG_BURST_W-1:0] burstcount;
    } rd_tag_t;

    // A burstcount of zero moves exactly one beat.
    function automatic logic [TAG_BURST_W-1:0] eff_burst(input logic [TAG_BURST_W-1:0] bc);
        return (bc == '0) ? TAG_BURST_W'(1) : bc;
    endfunction

endpackage

// File: rtl/ofs_plat_avalon_mem_rr_arb_rd_fifo.sv
// ============================================================================
// ofs_plat_avalon_mem_rr_arb_rd_fifo
//
// Read-tracking FIFO holding one rd_tag_t per outstanding read command.
// Pointers are registered with an extra wrap bit; full/empty come straight
// from the pointer compare. Push and pop in the same cycle are accepted when
// full (the popped slot is the one overwritten); a pop while empty is ignored.
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset (empties the FIFO)
//   push        - write push_data at the tail
//   push_data   - tag to store
//   pop         - discard the head entry
//   head        - current head entry (valid when !empty)
//   full, empty - occupancy flags
// ============================================================================
module ofs_plat_avalon_mem_rr_arb_rd_fifo
    import ofs_plat_avalon_mem_rr_arb_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  rd_tag_t push_data,
    input  logic    pop,
    output rd_tag_t head,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    rd_tag_t        tag_mem [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head  = tag_mem[rd_ptr_q[PTR_W-1:0]];

    // A push at full is only legal when the head leaves in the same cycle.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            tag_mem[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ofs_plat_avalon_mem_rr_arb.sv
// ============================================================================
// ofs_plat_avalon_mem_rr_arb
//
// Round-robin arbiter letting NUM_PORTS Avalon-MM sources share one memory
// bank. The winning command is steered combinationally to the sink; write
// bursts lock the sink to their source until the last beat. Read responses
// are routed back in issue order using a read-tracking FIFO of
// {port, burstcount} tags.
//
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   src_*                   - per-source command buses, packed port-major
//   src_waitrequest         - per-source backpressure (1 = not accepted)
//   src_readdata            - shared response data
//   src_readdatavalid       - per-source response strobe
//   snk_*                   - single memory-side Avalon-MM master
//   stat_grants             - per-port accepted-command counters (32b each)
//
// Build option:
//   OFS_PLAT_AVALON_MEM_RR_ARB_STATS_EN - when defined, stat_grants holds
//   saturating per-port grant counters; otherwise it is tied to zero.
// ============================================================================
module ofs_plat_avalon_mem_rr_arb
    import ofs_plat_avalon_mem_rr_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_WIDTH      = 27,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int RD_TRACK_DEPTH  = 64
) (
    input  logic                                  clk,
    input  logic                                  reset,

    input  logic [NUM_PORTS-1:0]                  src_read,
    input  logic [NUM_PORTS-1:0]                  src_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       src_address,
    input  logic [NUM_PORTS*BURST_CNT_WIDTH-1:0]  src_burstcount,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]       src_writedata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]     src_byteenable,
    output logic [NUM_PORTS-1:0]                  src_waitrequest,
    output logic [DATA_WIDTH-1:0]                 src_readdata,
    output logic [NUM_PORTS-1:0]                  src_readdatavalid,

    output logic                                  snk_read,
    output logic                                  snk_write,
    output logic [ADDR_WIDTH-1:0]                 snk_address,
    output logic [BURST_CNT_WIDTH-1:0]            snk_burstcount,
    output logic [DATA_WIDTH-1:0]                 snk_writedata,
    output logic [DATA_WIDTH/8-1:0]               snk_byteenable,
    input  logic                                  snk_waitrequest,
    input  logic [DATA_WIDTH-1:0]                 snk_readdata,
    input  logic                                  snk_readdatavalid,

    output logic [NUM_PORTS*32-1:0]               stat_grants
);

    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int BE_W   = DATA_WIDTH / 8;

    arb_state_t                 state_q, state_d;
    logic [PORT_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PORT_W-1:0]          lock_port_q, lock_port_d;
    logic [BURST_CNT_WIDTH-1:0] beats_left_q, beats_left_d;
    logic [TAG_BURST_W-1:0]     rd_beat_cnt_q, rd_beat_cnt_d;

    logic [NUM_PORTS-1:0]       eligible;
    logic                       grant_valid;
    logic [PORT_W-1:0]          grant_port;
    logic                       cmd_accept;
    logic                       rd_push, rd_pop, head_hit;
    logic                       fifo_full, fifo_empty;
    rd_tag_t                    fifo_head, push_tag;

    // (base + offs) modulo NUM_PORTS, for offs < NUM_PORTS.
    function automatic logic [PORT_W-1:0] port_add(input logic [PORT_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
        return PORT_W'(sum);
    endfunction

    // Winner selection. Reads are not eligible while the tracking FIFO is
    // full, so writes keep flowing. Scanning from the farthest offset down
    // leaves the port nearest at-or-after rr_ptr as the winner.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            eligible[p] = src_write[p] || (src_read[p] && !fifo_full);
        end
        if (state_q == ST_WR_BURST) begin
            grant_port  = lock_port_q;
            grant_valid = src_write[lock_port_q];
        end else begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (eligible[port_add(rr_ptr_q, i)]) begin
                    grant_valid = 1'b1;
                    grant_port  = port_add(rr_ptr_q, i);
                end
            end
        end
    end

    // Sink steering. A port presenting both read and write is treated as a
    // write; reads are never forwarded during a locked burst. Reset gates
    // all handshakes so nothing is accepted while it is held.
    always_comb begin
        snk_read        = 1'b0;
        snk_write       = 1'b0;
        snk_address     = src_address[grant_port*ADDR_WIDTH +: ADDR_WIDTH];
        snk_burstcount  = src_burstcount[grant_port*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
        snk_writedata   = src_writedata[grant_port*DATA_WIDTH +: DATA_WIDTH];
        snk_byteenable  = src_byteenable[grant_port*BE_W +: BE_W];
        src_waitrequest = '1;
        if (grant_valid && !reset) begin
            snk_write = src_write[grant_port];
            snk_read  = src_read[grant_port] && !src_write[grant_port] && (state_q == ST_IDLE);
            src_waitrequest[grant_port] = snk_waitrequest;
        end
    end

    assign cmd_accept = (snk_read || snk_write) && !snk_waitrequest;

    // Command state: rotate priority past every accepted winner and lock the
    // sink for multi-beat writes until the final beat is taken.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_port_d  = lock_port_q;
        beats_left_d = beats_left_q;
        if (cmd_accept) begin
            rr_ptr_d = port_add(grant_port, 1);
            if (state_q == ST_IDLE) begin
                if (snk_write && (snk_burstcount > BURST_CNT_WIDTH'(1))) begin
                    state_d      = ST_WR_BURST;
                    lock_port_d  = grant_port;
                    beats_left_d = snk_burstcount - BURST_CNT_WIDTH'(1);
                end
            end else begin
                beats_left_d = beats_left_q - BURST_CNT_WIDTH'(1);
                if (beats_left_q == BURST_CNT_WIDTH'(1)) begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // Read tracking: tag each accepted read, route each response beat to the
    // head tag's port, and retire the head on its last beat.
    always_comb begin
        push_tag.port       = TAG_PORT_W'(grant_port);
        push_tag.burstcount = eff_burst(TAG_BURST_W'(snk_burstcount));
        rd_push             = cmd_accept && snk_read;
        head_hit            = snk_readdatavalid && !fifo_empty;
        rd_pop              = 1'b0;
        rd_beat_cnt_d       = rd_beat_cnt_q;
        if (head_hit) begin
            if (rd_beat_cnt_q + TAG_BURST_W'(1) == fifo_head.burstcount) begin
                rd_pop        = 1'b1;
                rd_beat_cnt_d = '0;
            end else begin
                rd_beat_cnt_d = rd_beat_cnt_q + TAG_BURST_W'(1);
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            src_readdatavalid[p] = head_hit && (fifo_head.port == TAG_PORT_W'(p));
        end
    end

    assign src_readdata = snk_readdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            lock_port_q   <= '0;
            beats_left_q  <= '0;
            rd_beat_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            lock_port_q   <= lock_port_d;
            beats_left_q  <= beats_left_d;
            rd_beat_cnt_q <= rd_beat_cnt_d;
        end
    end

    ofs_plat_avalon_mem_rr_arb_rd_fifo #(
        .DEPTH (RD_TRACK_DEPTH)
    ) rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_push),
        .push_data (push_tag),
        .pop       (rd_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A response with nothing outstanding has no destination and is dropped.
    assert property (@(posedge clk) disable iff (reset) !(snk_readdatavalid && fifo_empty));

`ifdef OFS_PLAT_AVALON_MEM_RR_ARB_STATS_EN
    logic [NUM_PORTS-1:0][31:0] grant_cnt_q, grant_cnt_d;

    // One count per command: burst continuation beats are not counted.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (cmd_accept && (state_q == ST_IDLE) && (grant_cnt_q[grant_port] != 32'hFFFF_FFFF)) begin
            grant_cnt_d[grant_port] = grant_cnt_q[grant_port] + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign stat_grants = grant_cnt_q;
`else
    assign stat_grants = '0;
`endif

endmodule
